nibble_skip_scheduler: RTL and testbench
========================================

Name: nibble_skip_scheduler

Overview:
Sequences one weight word through a shared external nibble multiplier, one weight nibble per cycle. Zero-valued nibbles are skipped outright: they cost no cycle and issue no multiply. The block shifts each returned partial product into place and accumulates it, then presents the full product on a valid/ready output. It sits in the PE in front of the nibble multiplier and replaces static per-nibble zero gating with dynamic zero-skip sequencing.

Parameters:
LOG2_NIBBLE_WIDTH, 2, log2 of nibble width
NIBBLE_WIDTH, 2**LOG2_NIBBLE_WIDTH, bits per weight nibble
NUM_NIBBLES, 4, nibbles per weight word; WEIGHT_WIDTH = NUM_NIBBLES*NIBBLE_WIDTH
ACT_WIDTH, 8, activation width (unsigned)
PP_WIDTH, ACT_WIDTH+NIBBLE_WIDTH, partial-product width
RES_WIDTH, ACT_WIDTH+NUM_NIBBLES*NIBBLE_WIDTH, result width
CNT_WIDTH, 16, skip-counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  weight/activation pair offered
in_ready  out  1  block can accept a pair
in_weight  in  WEIGHT_WIDTH  weight word, unsigned
in_act  in  ACT_WIDTH  activation, unsigned
mul_valid  out  1  nibble issued to the multiplier this cycle
mul_nibble  out  NIBBLE_WIDTH  issued weight nibble
mul_act  out  ACT_WIDTH  latched activation
mul_idx  out  clog2(NUM_NIBBLES)  index of the issued nibble
mul_pp  in  PP_WIDTH  multiplier result, combinational and same-cycle
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_result  out  RES_WIDTH  weight*act
skip_clear  in  1  synchronous clear of skip_count
skip_count  out  CNT_WIDTH  saturating count of skipped zero nibbles

Behaviour:
- FSM states: IDLE, RUN, DONE. Async rst forces IDLE from any state, including mid-RUN or mid-DONE, and abandons any in-flight word.
- Reset values: in_ready=1, out_valid=0, mul_valid=0, out_result=0, skip_count=0. mul_nibble, mul_act and mul_idx reset to 0.
- IDLE: in_ready=1. On in_valid & in_ready at cycle T:
  - latch weight and act;
  - form pending mask: bit i = |nibble i;
  - clear acc;
  - skip_count += NUM_NIBBLES - popcount(mask), saturating at all-ones;
  - next state is DONE if mask==0, else RUN.
- RUN: in_ready=0, mul_valid=1, mul_idx = lowest set bit of pending, mul_nibble = that nibble.
  - Each cycle: acc += mul_pp << (mul_idx*NIBBLE_WIDTH), computed at RES_WIDTH with zero-extension; clear that pending bit.
  - If the cleared bit was the last one, go to DONE.
  - Exactly popcount(mask) RUN cycles, nibbles issued in ascending index order.
- DONE: out_valid=1, out_result=acc, mul_valid=0, in_ready=0.
  - Hold out_result stable while out_ready=0.
  - On out_ready, go to IDLE. The next accept cannot occur in the same cycle (no bypass).
- Latency: accept at T with k nonzero nibbles gives out_valid from T+k+1. For an all-zero weight, out_valid at T+1 with out_result=0.
- mul_nibble, mul_act and mul_idx are don't-care when mul_valid=0 but must not toggle; they hold their last value.
- skip_clear:
  - takes priority over a same-cycle increment; the count becomes 0 and that cycle's increment is dropped;
  - does not affect the FSM.
- in_valid while not in IDLE is ignored. The upstream source must hold the pair until in_ready.
- Arithmetic is unsigned; no overflow is possible at RES_WIDTH.

Decomposition:
- Shared Verilog header (`include) holds:
  - FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIBBLE_WIDTH and NUM_NIBBLES defaults, shared with the multiplier and the PE array.
- One sub-module: nibble_prio_enc. It is combinational and takes the NUM_NIBBLES mask. It produces the lowest-set index, an any-set flag, and a one-hot clear vector. The FSM, accumulator and counter stay in the top module.

Test Plan:
1. Zero weight: weight=0x0000, act=0x5A, out_ready=1 -> mul_valid never asserts; out_valid at T+1, out_result=0; skip_count=4.
2. Dense weight: weight=0x1234, act=0x03 -> 4 RUN cycles with mul_idx 0,1,2,3 and nibbles 4,3,2,1; out_valid at T+5, out_result=0x0369C; skip_count unchanged.
3. Sparse weight: weight=0x0F00, act=0xFF -> one RUN cycle with mul_idx=2, mul_nibble=0xF; out_valid at T+2, out_result=0xEF100; skip_count += 3.
4. Backpressure: scenario 2 with out_ready=0 for 3 cycles after out_valid -> out_result held at 0x0369C, in_ready=0 throughout; IDLE in the cycle after out_ready=1.
5. Reset mid-RUN: assert rst during the 2nd RUN cycle of 0x1234 -> next edge shows in_ready=1, out_valid=0, mul_valid=0, skip_count=0; a fresh 0x0001*0x07 then yields out_result=7.
6. Counter: preload near saturation by issuing zero weights, with skip_clear pulsed coincident with an accept -> skip_count=0 after the clear, and saturation at 0xFFFF with no wrap.

Source files
------------

// File: rtl/nibble_skip_scheduler_pkg.sv
// Shared definitions for the nibble zero-skip scheduler: FSM encodings and
// nibble geometry defaults also used by the nibble multiplier and the PE array.
package nibble_skip_scheduler_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int LOG2_NIBBLE_WIDTH_DEF = 2;
    localparam int NIBBLE_WIDTH_DEF      = 2 ** LOG2_NIBBLE_WIDTH_DEF;
    localparam int NUM_NIBBLES_DEF       = 4;

    // Index width that stays legal for a single-nibble word.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_skip_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder over the pending-nibble mask: index of the
// next nibble to issue, an any-pending flag and the one-hot bit to retire.
module nibble_prio_enc
    import nibble_skip_scheduler_pkg::*;
#(
    parameter int NUM_NIBBLES = NUM_NIBBLES_DEF,
    parameter int IDX_WIDTH   = idx_width(NUM_NIBBLES)
) (
    input  logic [NUM_NIBBLES-1:0] mask_i,
    output logic [IDX_WIDTH-1:0]   idx_o,
    output logic                   any_o,
    output logic [NUM_NIBBLES-1:0] clr_o
);

    always_comb begin
        idx_o = '0;
        any_o = |mask_i;
        // Two's-complement trick isolates the lowest set bit.
        clr_o = mask_i & (~mask_i + NUM_NIBBLES'(1));
        for (int i = NUM_NIBBLES - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IDX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/nibble_skip_scheduler.sv
// Sequences one weight word through a shared nibble multiplier, skipping zero
// nibbles, accumulating shifted partial products into a full weight*act product.
module nibble_skip_scheduler
    import nibble_skip_scheduler_pkg::*;
#(
    parameter int LOG2_NIBBLE_WIDTH = LOG2_NIBBLE_WIDTH_DEF,
    parameter int NIBBLE_WIDTH      = 2 ** LOG2_NIBBLE_WIDTH,
    parameter int NUM_NIBBLES       = NUM_NIBBLES_DEF,
    parameter int ACT_WIDTH         = 8,
    parameter int PP_WIDTH          = ACT_WIDTH + NIBBLE_WIDTH,
    parameter int RES_WIDTH         = ACT_WIDTH + NUM_NIBBLES * NIBBLE_WIDTH,
    parameter int CNT_WIDTH         = 16,
    localparam int WEIGHT_WIDTH     = NUM_NIBBLES * NIBBLE_WIDTH,
    localparam int IDX_WIDTH        = idx_width(NUM_NIBBLES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WEIGHT_WIDTH-1:0] in_weight,
    input  logic [ACT_WIDTH-1:0]    in_act,
    output logic                    mul_valid,
    output logic [NIBBLE_WIDTH-1:0] mul_nibble,
    output logic [ACT_WIDTH-1:0]    mul_act,
    output logic [IDX_WIDTH-1:0]    mul_idx,
    input  logic [PP_WIDTH-1:0]     mul_pp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RES_WIDTH-1:0]    out_result,
    input  logic                    skip_clear,
    output logic [CNT_WIDTH-1:0]    skip_count
);

    function automatic int popcount(input logic [NUM_NIBBLES-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < NUM_NIBBLES; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input int b);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, a} + (CNT_WIDTH + 1)'(b);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    logic [1:0]              state_q, state_d;
    logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
    logic [ACT_WIDTH-1:0]    act_q, act_d;
    logic [NUM_NIBBLES-1:0]  pend_q, pend_d, in_mask, pend_left;
    logic [RES_WIDTH-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d, enc_idx;
    logic [NIBBLE_WIDTH-1:0] nib_q, nib_d, cur_nib;
    logic                    enc_any;
    logic [NUM_NIBBLES-1:0]  enc_clr;

    nibble_prio_enc #(
        .NUM_NIBBLES(NUM_NIBBLES),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_prio_enc (
        .mask_i(pend_q),
        .idx_o (enc_idx),
        .any_o (enc_any),
        .clr_o (enc_clr)
    );

    always_comb begin
        for (int i = 0; i < NUM_NIBBLES; i++) begin
            in_mask[i] = |in_weight[i*NIBBLE_WIDTH +: NIBBLE_WIDTH];
        end
    end

    assign cur_nib   = weight_q[int'(enc_idx) * NIBBLE_WIDTH +: NIBBLE_WIDTH];
    assign pend_left = pend_q & ~enc_clr;

    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        act_d    = act_q;
        pend_d   = pend_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        nib_d    = nib_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    weight_d = in_weight;
                    pend_d   = in_mask;
                    acc_d    = '0;
                    cnt_d    = sat_add(cnt_q, NUM_NIBBLES - popcount(in_mask));
                    // Activation only moves when it will be issued, so mul_act stays quiet otherwise.
                    if (|in_mask) begin
                        act_d   = in_act;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                acc_d  = acc_q + (RES_WIDTH'(mul_pp) << (int'(enc_idx) * NIBBLE_WIDTH));
                pend_d = pend_left;
                idx_d  = enc_idx;
                nib_d  = cur_nib;
                if (pend_left == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (skip_clear) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            weight_q <= '0;
            act_q    <= '0;
            pend_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            nib_q    <= '0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            nib_q    <= nib_d;
        end
    end

    // Outside RUN the issue fields replay the last issued nibble instead of tracking pend_q.
    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign mul_valid  = (state_q == ST_RUN) && enc_any;
    assign mul_idx    = (state_q == ST_RUN) ? enc_idx : idx_q;
    assign mul_nibble = (state_q == ST_RUN) ? cur_nib : nib_q;
    assign mul_act    = act_q;
    assign out_result = acc_q;
    assign skip_count = cnt_q;

endmodule

// File: tb/tb_nibble_skip_scheduler.sv
// Self-checking bench for nibble_skip_scheduler with a behavioural product/skip model.
module tb_nibble_skip_scheduler;

    localparam int NW   = 4;
    localparam int NN   = 4;
    localparam int AW   = 8;
    localparam int WW   = NN * NW;
    localparam int PPW  = AW + NW;
    localparam int RESW = AW + WW;
    localparam int CW   = 16;
    localparam int CMAX = 65535;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [WW-1:0]   in_weight = '0;
    logic [AW-1:0]   in_act = '0;
    logic            mul_valid;
    logic [NW-1:0]   mul_nibble;
    logic [AW-1:0]   mul_act;
    logic [1:0]      mul_idx;
    logic [PPW-1:0]  mul_pp;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [RESW-1:0] out_result;
    logic            skip_clear = 1'b0;
    logic [CW-1:0]   skip_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_skip = 0;

    always #5 clk = ~clk;

    // External nibble multiplier: combinational, same-cycle.
    assign mul_pp = PPW'(mul_nibble) * PPW'(mul_act);

    nibble_skip_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_weight (in_weight),
        .in_act    (in_act),
        .mul_valid (mul_valid),
        .mul_nibble(mul_nibble),
        .mul_act   (mul_act),
        .mul_idx   (mul_idx),
        .mul_pp    (mul_pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .skip_clear(skip_clear),
        .skip_count(skip_count)
    );

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic test_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (mul_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mul_valid got %b want 0", mul_valid); end
        vectors++; if (out_result !== '0) begin miscompares++; $display("FAIL reset_out_result got %0h want 0", out_result); end
        vectors++; if (skip_count !== '0) begin miscompares++; $display("FAIL reset_skip_count got %0d want 0", skip_count); end
        vectors++; if ({mul_nibble, mul_act, mul_idx} !== '0) begin miscompares++; $display("FAIL reset_mul_fields got %0h/%0h/%0h want 0", mul_nibble, mul_act, mul_idx); end
    endtask

    // Offers one word at a negedge in IDLE and checks the whole transaction.
    task automatic run_word(input logic [WW-1:0] w, input logic [AW-1:0] a, input int bp,
                            input bit noise);
        int idxq[$];
        int k;
        logic [RESW-1:0] prod;
        logic [AW-1:0] prev_act;
        for (int i = 0; i < NN; i++) if (w[i*NW +: NW] != 0) idxq.push_back(i);
        k = idxq.size();
        prod = RESW'(w) * RESW'(a);
        prev_act = mul_act;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL pre_accept_in_ready w=%0h got %b want 1", w, in_ready); end
        in_valid = 1'b1; in_weight = w; in_act = a; out_ready = (bp == 0);
        @(posedge clk);
        exp_skip = sat(exp_skip + NN - k);
        @(negedge clk);
        for (int c = 0; c < k; c++) begin
            in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in_weight = WW'($urandom); in_act = AW'($urandom);
            vectors++; if (mul_valid !== 1'b1) begin miscompares++; $display("FAIL run_mul_valid w=%0h c=%0d got %b want 1", w, c, mul_valid); end
            vectors++; if (mul_idx !== 2'(idxq[c])) begin miscompares++; $display("FAIL run_mul_idx w=%0h c=%0d got %0d want %0d", w, c, mul_idx, idxq[c]); end
            vectors++; if (mul_nibble !== w[idxq[c]*NW +: NW]) begin miscompares++; $display("FAIL run_mul_nibble w=%0h c=%0d got %0h want %0h", w, c, mul_nibble, w[idxq[c]*NW +: NW]); end
            vectors++; if (mul_act !== a) begin miscompares++; $display("FAIL run_mul_act w=%0h got %0h want %0h", w, mul_act, a); end
            vectors++; if ({in_ready, out_valid} !== 2'b00) begin miscompares++; $display("FAIL run_handshake w=%0h got in_ready=%b out_valid=%b want 0/0", w, in_ready, out_valid); end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        for (int j = 0; j <= bp; j++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL done_out_valid w=%0h j=%0d got %b want 1", w, j, out_valid); end
            vectors++; if (out_result !== prod) begin miscompares++; $display("FAIL done_out_result w=%0h a=%0h got %0h want %0h", w, a, out_result, prod); end
            vectors++; if ({in_ready, mul_valid} !== 2'b00) begin miscompares++; $display("FAIL done_ctrl w=%0h got in_ready=%b mul_valid=%b want 0/0", w, in_ready, mul_valid); end
            vectors++; if (skip_count !== CW'(exp_skip)) begin miscompares++; $display("FAIL done_skip_count w=%0h got %0d want %0d", w, skip_count, exp_skip); end
            if (k > 0) begin
                vectors++; if (mul_idx !== 2'(idxq[k-1])) begin miscompares++; $display("FAIL done_mul_idx_hold w=%0h got %0d want %0d", w, mul_idx, idxq[k-1]); end
            end else begin
                vectors++; if (mul_act !== prev_act) begin miscompares++; $display("FAIL zero_mul_act_hold got %0h want %0h", mul_act, prev_act); end
            end
            if (j == bp) out_ready = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        vectors++; if ({in_ready, out_valid} !== 2'b10) begin miscompares++; $display("FAIL return_idle w=%0h got in_ready=%b out_valid=%b want 1/0", w, in_ready, out_valid); end
    endtask

    task automatic test_directed();
        run_word(16'h0000, 8'h5A, 0, 1'b0);
        run_word(16'h1234, 8'h03, 0, 1'b0);
        run_word(16'h0F00, 8'hFF, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_word(16'h1234, 8'h03, 3, 1'b0);
    endtask

    task automatic test_random();
        logic [WW-1:0] w;
        for (int n = 0; n < 60; n++) begin
            w = '0;
            for (int i = 0; i < NN; i++)
                if ($urandom_range(0, 1) == 1) w[i*NW +: NW] = NW'($urandom_range(1, 15));
            run_word(w, AW'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1; in_weight = 16'h1234; in_act = 8'h03; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++; if (mul_idx !== 2'd1) begin miscompares++; $display("FAIL midrun_second_idx got %0d want 1", mul_idx); end
        rst = 1'b1;
        #1;
        exp_skip = 0;
        vectors++; if ({in_ready, out_valid, mul_valid} !== 3'b100) begin miscompares++; $display("FAIL midrun_async_ctrl got %b want 100", {in_ready, out_valid, mul_valid}); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        vectors++; if ({in_ready, out_valid, mul_valid} !== 3'b100) begin miscompares++; $display("FAIL midrun_after_edge_ctrl got %b want 100", {in_ready, out_valid, mul_valid}); end
        vectors++; if (skip_count !== '0) begin miscompares++; $display("FAIL midrun_skip_count got %0d want 0", skip_count); end
        run_word(16'h0001, 8'h07, 0, 1'b0);
    endtask

    task automatic zero_fast();
        in_valid = 1'b1; in_weight = '0; out_ready = 1'b1;
        @(posedge clk);
        exp_skip = sat(exp_skip + NN);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_counter();
        run_word(16'h0000, 8'h11, 0, 1'b0);
        in_valid = 1'b1; in_weight = '0; skip_clear = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        exp_skip = 0;
        @(negedge clk);
        in_valid = 1'b0; skip_clear = 1'b0;
        vectors++; if (skip_count !== '0) begin miscompares++; $display("FAIL clear_on_accept got %0d want 0", skip_count); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL clear_keeps_fsm got out_valid=%b want 1", out_valid); end
        @(posedge clk); @(negedge clk);
        for (int n = 0; n < 16383; n++) zero_fast();
        vectors++; if (skip_count !== CW'(exp_skip)) begin miscompares++; $display("FAIL near_sat got %0d want %0d", skip_count, exp_skip); end
        zero_fast();
        vectors++; if (skip_count !== 16'hFFFF) begin miscompares++; $display("FAIL saturate got %0h want ffff", skip_count); end
        zero_fast();
        vectors++; if (skip_count !== 16'hFFFF) begin miscompares++; $display("FAIL no_wrap got %0h want ffff", skip_count); end
        run_word(16'h00A0, 8'h21, 1, 1'b0);
        skip_clear = 1'b1;
        @(posedge clk);
        exp_skip = 0;
        @(negedge clk);
        skip_clear = 1'b0;
        vectors++; if (skip_count !== '0) begin miscompares++; $display("FAIL clear_idle got %0d want 0", skip_count); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        test_counter();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
